// File: rtl/addrwin_pkg.sv
// rtl/addrwin_pkg.sv - shared types and constants for the I/O address-window decoder
// Build option: ADDRWIN_MISS_CNT_EN enables the decode-miss counter in addrwin_decoder.
package addrwin_pkg;

  localparam int WIN_ADDR_W = 16;  // host I/O address width carried in a window entry
  localparam int SLOT_W     = 3;   // peripheral slot code width
  localparam int IDX_W      = 3;   // window index width
  localparam int MISS_CNT_W = 16;  // decode-miss counter width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MATCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  en;
    logic [WIN_ADDR_W-1:0] base;
    logic [WIN_ADDR_W-1:0] mask;  // 1 = bit is compared
    logic [SLOT_W-1:0]     slot;
  } win_t;

endpackage

// File: rtl/addrwin_prio_match.sv
// rtl/addrwin_prio_match.sv - combinational fixed-priority window match
// Ports:
//   win_table - the window table (entry 0 has the highest priority)
//   addr_i    - latched host address to decode
//   hit_o     - at least one enabled window matched
//   idx_o     - index of the lowest matching window (0 on no hit)
//   slot_o    - slot of the lowest matching window (0 on no hit)
module addrwin_prio_match
  import addrwin_pkg::*;
#(
  parameter int NUM_WINDOWS = 8
) (
  input  win_t [NUM_WINDOWS-1:0] win_table,
  input  logic [WIN_ADDR_W-1:0]  addr_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic [SLOT_W-1:0]      slot_o
);

  // Scan from the highest index down so the lowest hitting index is the last
  // assignment and therefore wins.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    slot_o = '0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if (win_table[i].en &&
          ((addr_i & win_table[i].mask) == (win_table[i].base & win_table[i].mask))) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        slot_o = win_table[i].slot;
      end
    end
  end

endmodule

// File: rtl/addrwin_decoder.sv
// rtl/addrwin_decoder.sv - programmable I/O address-window decoder with write-once lock
// Build option: ADDRWIN_MISS_CNT_EN builds a saturating decode-miss counter;
// when undefined miss_count is tied to 0.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   iorq_n, addr     - host /IORQ (asynchronous) and I/O address
//   cfg_we .. cfg_lock - window table write port
//   cfg_ready        - a table write can be accepted this cycle
//   cfg_err          - one-cycle pulse after a rejected write
//   win_valid, sel_slot, win_idx - decode result, held until /IORQ deasserts
//   miss_count       - number of transactions that matched no window
module addrwin_decoder
  import addrwin_pkg::*;
#(
  parameter int NUM_WINDOWS = 8,
  parameter int ADDR_W      = WIN_ADDR_W,
  parameter int NUM_SLOTS   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iorq_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W-1:0]     cfg_mask,
  input  logic [SLOT_W-1:0]     cfg_slot,
  input  logic                  cfg_en,
  input  logic                  cfg_lock,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic                  win_valid,
  output logic [SLOT_W-1:0]     sel_slot,
  output logic [IDX_W-1:0]      win_idx,
  output logic [MISS_CNT_W-1:0] miss_count
);

  state_e                  state_q, state_d;
  logic                    iorq_meta_q, iorq_meta_d;
  logic                    iorq_s_q, iorq_s_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  win_t [NUM_WINDOWS-1:0]  table_q, table_d;
  logic                    lock_q, lock_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    win_valid_q, win_valid_d;
  logic [SLOT_W-1:0]       sel_slot_q, sel_slot_d;
  logic [IDX_W-1:0]        win_idx_q, win_idx_d;

  logic                    m_hit;
  logic [IDX_W-1:0]        m_idx;
  logic [SLOT_W-1:0]       m_slot;
  logic                    cfg_legal;
  logic                    cfg_accept;

  addrwin_prio_match #(
    .NUM_WINDOWS (NUM_WINDOWS)
  ) u_match (
    .win_table (table_q),
    .addr_i    (addr_q),
    .hit_o     (m_hit),
    .idx_o     (m_idx),
    .slot_o    (m_slot)
  );

  assign cfg_ready  = (state_q == S_IDLE) && !lock_q;
  assign cfg_legal  = (int'(cfg_idx) < NUM_WINDOWS) && (int'(cfg_slot) < NUM_SLOTS);
  assign cfg_accept = cfg_we && cfg_ready && cfg_legal;

  always_comb begin
    // Two-flop /IORQ synchronizer
    iorq_meta_d = iorq_n;
    iorq_s_d    = iorq_meta_q;

    state_d     = state_q;
    addr_d      = addr_q;
    table_d     = table_q;
    lock_d      = lock_q;
    win_valid_d = win_valid_q;
    sel_slot_d  = sel_slot_q;
    win_idx_d   = win_idx_q;
    cfg_err_d   = cfg_we && !cfg_accept;

    if (cfg_accept) begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (int'(cfg_idx) == i) begin
          table_d[i].en   = cfg_en;
          table_d[i].base = cfg_base;
          table_d[i].mask = cfg_mask;
          table_d[i].slot = cfg_slot;
        end
      end
      if (cfg_lock) begin
        lock_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        win_valid_d = 1'b0;
        sel_slot_d  = '0;
        win_idx_d   = '0;
        if (!iorq_s_q) begin
          addr_d  = addr;
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        // A table write on the preceding IDLE edge is already in table_q here.
        win_valid_d = m_hit;
        sel_slot_d  = m_slot;
        win_idx_d   = m_idx;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (iorq_s_q) begin
          win_valid_d = 1'b0;
          sel_slot_d  = '0;
          win_idx_d   = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        win_valid_d = 1'b0;
        sel_slot_d  = '0;
        win_idx_d   = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iorq_meta_q <= 1'b1;
      iorq_s_q    <= 1'b1;
      addr_q      <= '0;
      table_q     <= '0;
      lock_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      win_valid_q <= 1'b0;
      sel_slot_q  <= '0;
      win_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      iorq_meta_q <= iorq_meta_d;
      iorq_s_q    <= iorq_s_d;
      addr_q      <= addr_d;
      table_q     <= table_d;
      lock_q      <= lock_d;
      cfg_err_q   <= cfg_err_d;
      win_valid_q <= win_valid_d;
      sel_slot_q  <= sel_slot_d;
      win_idx_q   <= win_idx_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign win_valid = win_valid_q;
  assign sel_slot  = sel_slot_q;
  assign win_idx   = win_idx_q;

`ifdef ADDRWIN_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_MATCH) && !m_hit && (miss_cnt_q != {MISS_CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_addrwin_decoder.sv
// tb/tb_addrwin_decoder.sv - directed self-checking bench for addrwin_decoder
module tb_addrwin_decoder;

  logic        clk;
  logic        rst_n;
  logic        iorq_n;
  logic [15:0] addr;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_base;
  logic [15:0] cfg_mask;
  logic [2:0]  cfg_slot;
  logic        cfg_en;
  logic        cfg_lock;
  logic        cfg_ready;
  logic        cfg_err;
  logic        win_valid;
  logic [2:0]  sel_slot;
  logic [2:0]  win_idx;
  logic [15:0] miss_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_miss_cnt = 0;

  addrwin_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iorq_n     (iorq_n),
    .addr       (addr),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_base   (cfg_base),
    .cfg_mask   (cfg_mask),
    .cfg_slot   (cfg_slot),
    .cfg_en     (cfg_en),
    .cfg_lock   (cfg_lock),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .win_valid  (win_valid),
    .sel_slot   (sel_slot),
    .win_idx    (win_idx),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_miss();
`ifdef ADDRWIN_MISS_CNT_EN
    return 16'(exp_miss_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic cfg_wr(input logic [2:0] idx, input logic [15:0] base, input logic [15:0] mask,
                        input logic [2:0] slot, input logic en, input logic lock,
                        input logic exp_err);
    cfg_idx  = idx;
    cfg_base = base;
    cfg_mask = mask;
    cfg_slot = slot;
    cfg_en   = en;
    cfg_lock = lock;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
    tick();
    chk("cfg_err_pulse_end", cfg_err, 1'b0);
  endtask

  // Full host cycle: win_valid appears after the 4th edge with /IORQ low and
  // clears on the 3rd edge after /IORQ returns high.
  task automatic do_io(input logic [15:0] a, input logic ev, input logic [2:0] es,
                       input logic [2:0] ei);
    addr   = a;
    iorq_n = 1'b0;
    repeat (3) tick();
    chk("valid_before_match", win_valid, 1'b0);
    tick();
    chk("win_valid", win_valid, ev);
    chk("sel_slot", sel_slot, es);
    chk("win_idx", win_idx, ei);
    chk("ready_in_hold", cfg_ready, 1'b0);
    if (!ev) exp_miss_cnt++;
    chk("miss_count", miss_count, exp_miss());
    iorq_n = 1'b1;
    repeat (2) tick();
    chk("valid_held", win_valid, ev);
    tick();
    chk("valid_cleared", win_valid, 1'b0);
    chk("slot_cleared", sel_slot, 3'd0);
    chk("idx_cleared", win_idx, 3'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    iorq_n   = 1'b1;
    addr     = '0;
    cfg_we   = 1'b0;
    cfg_idx  = '0;
    cfg_base = '0;
    cfg_mask = '0;
    cfg_slot = '0;
    cfg_en   = 1'b0;
    cfg_lock = 1'b0;
    #1;
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_sel_slot", sel_slot, 3'd0);
    chk("rst_win_idx", win_idx, 3'd0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_miss_count", miss_count, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", cfg_ready, 1'b1);

    // Empty table: any access misses
    do_io(16'h0085, 1'b0, 3'd0, 3'd0);

    // win0 = 0x008x -> slot 2
    cfg_wr(3'd0, 16'h0080, 16'hFFF0, 3'd2, 1'b1, 1'b0, 1'b0);
    do_io(16'h0085, 1'b1, 3'd2, 3'd0);

    // Illegal slot code is rejected and win1 stays disabled
    cfg_wr(3'd1, 16'h0000, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1);
    do_io(16'h1234, 1'b0, 3'd0, 3'd0);
    do_io(16'h4000, 1'b0, 3'd0, 3'd0);

    // win1 = catch-all -> slot 4; win0 keeps priority where both hit
    cfg_wr(3'd1, 16'h0000, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0);
    do_io(16'h1234, 1'b1, 3'd4, 3'd1);
    do_io(16'h0081, 1'b1, 3'd2, 3'd0);

    // Write attempted while a transaction is held
    addr   = 16'h0081;
    iorq_n = 1'b0;
    repeat (4) tick();
    chk("hold_valid_for_wr", win_valid, 1'b1);
    chk("hold_ready", cfg_ready, 1'b0);
    cfg_idx  = 3'd0;
    cfg_base = 16'h0000;
    cfg_mask = 16'h0000;
    cfg_slot = 3'd3;
    cfg_en   = 1'b1;
    cfg_lock = 1'b0;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    chk("hold_wr_err", cfg_err, 1'b1);
    iorq_n = 1'b1;
    repeat (3) tick();
    do_io(16'h0081, 1'b1, 3'd2, 3'd0);

    // Glitch on /IORQ between edges never reaches the synchronizer
    #2 iorq_n = 1'b0;
    #3 iorq_n = 1'b1;
    repeat (6) tick();
    chk("glitch_valid", win_valid, 1'b0);
    chk("glitch_ready", cfg_ready, 1'b1);
    chk("glitch_miss", miss_count, exp_miss());

    // Locking write: win1 = 0x4xxx -> slot 3, then the table is frozen
    cfg_wr(3'd1, 16'h4000, 16'hF000, 3'd3, 1'b1, 1'b1, 1'b0);
    chk("ready_locked", cfg_ready, 1'b0);
    cfg_wr(3'd1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
    do_io(16'h4000, 1'b1, 3'd3, 3'd1);
    do_io(16'h1234, 1'b0, 3'd0, 3'd0);

    // Reset in S_HOLD aborts the transaction and clears table and lock
    addr   = 16'h0085;
    iorq_n = 1'b0;
    repeat (4) tick();
    chk("pre_rst_valid", win_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", win_valid, 1'b0);
    chk("midrst_slot", sel_slot, 3'd0);
    chk("midrst_idx", win_idx, 3'd0);
    chk("midrst_miss", miss_count, 16'h0000);
    iorq_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_miss_cnt = 0;
    tick();
    chk("ready_lock_cleared", cfg_ready, 1'b1);
    do_io(16'h0085, 1'b0, 3'd0, 3'd0);
    do_io(16'h4000, 1'b0, 3'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
